// File: rtl/wb_port_arbiter_pkg.sv
// wb_port_arbiter_pkg: shared state encoding, address-zero constant and width defaults
package wb_port_arbiter_pkg;
  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;
  localparam int ADDR_ZERO = 0;
  localparam int DEF_ADDR_W = 6;
  localparam int DEF_DATA_W = 32;
endpackage

// File: rtl/wb_port_arbiter_rr_arb2.sv
// rr_arb2: combinational 2-way round-robin grant; on contention the requester other than i_ptr wins
module rr_arb2 (
  input  logic [1:0] i_valid,
  input  logic       i_ptr,
  output logic [1:0] o_grant
);
  assign o_grant[0] = i_valid[0] && (!i_valid[1] || i_ptr);
  assign o_grant[1] = i_valid[1] && (!i_valid[0] || !i_ptr);
endmodule

// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter: two requesters share one registered write slot; writes to address 0 are swallowed
module wb_port_arbiter
  import wb_port_arbiter_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_req0_valid,
  input  logic [ADDR_W-1:0] i_req0_addr,
  input  logic [DATA_W-1:0] i_req0_data,
  output logic              o_req0_ready,
  input  logic              i_req1_valid,
  input  logic [ADDR_W-1:0] i_req1_addr,
  input  logic [DATA_W-1:0] i_req1_data,
  output logic              o_req1_ready,
  output logic              o_wr_en,
  output logic [ADDR_W-1:0] o_wr_addr,
  output logic [DATA_W-1:0] o_wr_data,
  output logic              o_sel,
  input  logic              i_wr_ready
);
  state_t            r_state, w_state_nxt;
  logic              r_ptr;
  logic [1:0]        w_grant;
  logic              w_free, w_win, w_load;
  logic [ADDR_W-1:0] w_addr;
  logic [DATA_W-1:0] w_data;
  rr_arb2 u_arb (
    .i_valid ({i_req1_valid, i_req0_valid}),
    .i_ptr   (r_ptr),
    .o_grant (w_grant)
  );
  assign o_wr_en      = r_state == FULL;
  assign w_free       = !i_rst && (!o_wr_en || i_wr_ready);
  assign o_req0_ready = w_free && w_grant[0];
  assign o_req1_ready = w_free && w_grant[1];
  assign w_win        = w_grant[1];
  assign w_addr       = w_win ? i_req1_addr : i_req0_addr;
  assign w_data       = w_win ? i_req1_data : i_req0_data;
  assign w_load       = (o_req0_ready || o_req1_ready) && w_addr != ADDR_W'(ADDR_ZERO);
  always_comb begin
    w_state_nxt = w_load ? FULL : (o_wr_en && i_wr_ready) ? EMPTY : r_state;
  end
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state   <= EMPTY;
      o_wr_addr <= '0;
      o_wr_data <= '0;
      o_sel     <= 1'b0;
      r_ptr     <= 1'b1;
    end else begin
      r_state <= w_state_nxt;
      if (w_load) begin
        o_wr_addr <= w_addr;
        o_wr_data <= w_data;
        o_sel     <= w_win;
        r_ptr     <= w_win;
      end
    end
  end
endmodule

// File: doc/wb_port_arbiter.md
WB_PORT_ARBITER -- requirements
Module: wb_port_arbiter

Interface
REQ-001 Parameter DATA_W, default 32, write data width.
REQ-002 Parameter ADDR_W, default 6, register address width; matches the 6-bit select mux datapath.
REQ-003 i_clk  input  1  single clock, all state on rising edge.
REQ-004 i_rst  input  1  reset, asynchronous, active-high.
REQ-005 i_req0_valid  input  1  requester 0 has a write pending.
REQ-006 i_req0_addr  input  ADDR_W  requester 0 destination address.
REQ-007 i_req0_data  input  DATA_W  requester 0 write data.
REQ-008 o_req0_ready  output  1  requester 0 transfer accepted this cycle.
REQ-009 i_req1_valid / i_req1_addr / i_req1_data / o_req1_ready: same as REQ-005..008 for requester 1.
REQ-010 o_wr_en  output  1  output register holds a valid write.
REQ-011 o_wr_addr  output  ADDR_W  registered winning address.
REQ-012 o_wr_data  output  DATA_W  registered winning data.
REQ-013 o_sel  output  1  mux select for the held write: 0 = requester 0, 1 = requester 1.
REQ-014 i_wr_ready  input  1  register-file write port consumes the held write this cycle.

Function
REQ-015 Transfer on requester N occurs when i_reqN_valid && o_reqN_ready; drain occurs when o_wr_en && i_wr_ready.
REQ-016 FSM states: EMPTY (o_wr_en=0), FULL (o_wr_en=1); EMPTY->FULL on accepted non-zero-address transfer; FULL->EMPTY on drain with no new non-zero-address transfer; FULL->FULL on drain plus new transfer.
REQ-017 Slot is free when state EMPTY or a drain occurs this cycle; ready to a requester is asserted only when the slot is free and that requester wins arbitration.
REQ-018 At most one o_reqN_ready high per cycle; ready is combinational from valids, pointer and slot-free; ready never depends on itself.
REQ-019 Arbitration: only one valid -> it wins; both valid -> the requester other than rr_ptr wins.
REQ-020 rr_ptr (1 bit) updates to the winner index on every accepted non-zero-address transfer; unchanged otherwise.
REQ-021 Latency: accepted transfer appears on o_wr_en/o_wr_addr/o_wr_data/o_sel on the next rising edge; sustained throughput 1 write per cycle when i_wr_ready stays high.
REQ-022 Address 0 (hardwired zero register): transfer is accepted when the slot is free, and ready is asserted, but the write is discarded; output register and rr_ptr are not updated.
REQ-023 Address-0 discard with both valid: the winner per REQ-019 is consumed; the other requester waits for the next cycle.
REQ-024 While FULL without drain, o_wr_en/o_wr_addr/o_wr_data/o_sel hold stable and both ready outputs are 0.
REQ-025 Requester inputs may change freely when valid is low; once valid is high, addr/data hold until ready (requester obligation; bench checks it).

Reset
REQ-026 i_rst high forces asynchronously: state EMPTY, o_wr_en=0, o_wr_addr=0, o_wr_data=0, o_sel=0, rr_ptr=1 (requester 0 wins first contention).
REQ-027 While i_rst is high both ready outputs are 0; a held write is dropped if reset asserts mid-operation.
REQ-028 First transfer is possible in the first cycle after i_rst deasserts.

Structure
REQ-029 Shared package holds state encoding (EMPTY=0, FULL=1), the address-zero constant, and ADDR_W/DATA_W defaults.
REQ-030 One sub-module, rr_arb2: combinational 2-way round-robin grant from valids and rr_ptr; the FSM, output register and pointer live in the top.

Verification
REQ-031 Reset: assert i_rst mid-FULL with o_wr_addr=5 -> o_wr_en=0, all outputs 0 immediately, readies 0.
REQ-032 Contention: both valid every cycle (req0 addr 3, req1 addr 7), i_wr_ready=1 -> o_sel sequence 0,1,0,1; o_wr_addr 3,7,3,7.
REQ-033 Backpressure: i_wr_ready=0 for 4 cycles with FULL -> outputs stable, both readies 0; i_wr_ready=1 -> drain and new transfer same cycle, FULL stays.
REQ-034 Zero address: req1 addr 0 data 0xDEADBEEF alone -> o_req1_ready=1, o_wr_en stays 0, rr_ptr unchanged.
REQ-035 Single requester: req1 only, addr 12 data 0x1234 -> o_wr_en=1, o_sel=1, o_wr_addr=12, o_wr_data=0x1234 one cycle after acceptance.
REQ-036 Random: 10k cycles random valids/addresses/i_wr_ready -> scoreboard matches order, no lost or duplicated write, no starvation beyond 1 grant.
